sampler_buffer_drain: RTL and testbench
=======================================

# sampler_buffer_drain

Downstream consumer of the lease sampler's reuse-interval buffer. After the host requests a dump, it walks the filled buffer entries over the sampler's read-address port and serializes each entry (PC/phase, interval, 64-bit trace stamp, target tag) into a 32-bit valid/ready word stream toward the host comm path. When the last word is accepted, it pulses a clear request so the sampler can resume logging.

## Interface
Parameters:
- BUFFER_DEPTH, 8192: number of buffer entries; `count_i` is clamped to this.
- ADDR_W, 13: buffer address width.

Ports:
- clock_i  in  1  single clock; every register samples on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle request to begin a drain; ignored while `busy_o`=1.
- abort_i  in  1  stops the drain and returns to IDLE; no clear pulse is issued.
- count_i  in  32  number of valid entries; sampled on the accepted start.
- buf_addr_o  out  ADDR_W  read address to the buffer BRAMs.
- buf_address_i  in  32  PC/phase word, one-cycle registered read.
- buf_interval_i  in  32  reuse interval; negative values mark table-dump entries.
- buf_trace_i  in  64  trace stamp.
- buf_target_i  in  32  target tag.
- out_data_o  out  32  stream word.
- out_valid_o  out  1  `out_data_o` holds a valid word.
- out_ready_i  in  1  consumer accepts the word this cycle.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a drain completes normally.
- sampler_clear_o  out  1  one-cycle pulse, asserted in the same cycle as `done_o`.
- words_sent_o  out  32  words accepted since the last start.

## Operation
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - The entry index and word index are 0.
- FSM states:
  - IDLE: on `start_i`, latch n = min(`count_i`, BUFFER_DEPTH) and zero `words_sent_o`. If n=0, go to DONE; otherwise drive `buf_addr_o`=0 and go to WAIT.
  - WAIT: one cycle for the BRAM read; then go to LATCH.
  - LATCH: capture all four buffer inputs into holding registers and set word index to 0; then go to SEND.
  - SEND: assert `out_valid_o`. Word order is address, interval, trace[31:0], trace[63:32], target (five words per entry). On valid&&ready, advance the word index. When word 4 is accepted:
    - if entry+1 < n, increment the entry, drive `buf_addr_o`=entry+1 and go to WAIT;
    - otherwise go to DONE.
  - DONE: pulse `done_o` and `sampler_clear_o` for one cycle; then go to IDLE.
- `buf_addr_o` is held stable from the cycle it is issued through LATCH. It holds its last value in SEND and IDLE.
- `words_sent_o` increments on every handshake. It saturates at 0xFFFFFFFF.
- `abort_i` is honoured in any state: next state is IDLE, `out_valid_o` drops, no pulses are issued, and `words_sent_o` holds its value. If abort and start arrive in the same cycle, abort wins and the start is dropped.
- `start_i` while busy is ignored with no side effects.
- The entry index never wraps because n ≤ BUFFER_DEPTH. When n = BUFFER_DEPTH, the last address is BUFFER_DEPTH-1.

## Timing
- Start accepted at edge k:
  - `buf_addr_o`=0 is valid after edge k (WAIT).
  - BRAM data is valid after edge k+1 (LATCH).
  - `out_valid_o`=1 after edge k+2.
- Each entry takes at least 7 cycles (WAIT, LATCH, 5×SEND); there is no prefetch.
- AXI-style stream rule: once `out_valid_o` is high, `out_data_o` stays stable and valid stays high until accepted.
- `out_valid_o` never depends combinationally on `out_ready_i`.
- Accepting the last word at edge m puts DONE after edge m, so `done_o`/`sampler_clear_o` are high for the cycle m..m+1. `busy_o` is 0 after edge m+1.
- Reset asserted mid-drain clears state immediately (asynchronous). No clear pulse follows.

## Structure
- Shared package `sampler_pkg` holds:
  - the state enum {IDLE, WAIT, LATCH, SEND, DONE};
  - the word-select enum;
  - WORDS_PER_ENTRY=5;
  - BUFFER_DEPTH/ADDR_W defaults, which are also used by the sampler.
- No sub-module: the FSM, holding registers and 5:1 output mux live in one module.

## Test plan
- count_i=2, ready always 1, buffer[0]={0x01000100, 5, 0x2A, 0xAB}: words 0x01000100, 5, 0x2A, 0x0, 0xAB, then entry 1. `done_o`/`sampler_clear_o` pulse once, `words_sent_o`=10, and `out_valid_o` first rises 2 cycles after start.
- count_i=0 -> no `out_valid_o`; `done_o` and `sampler_clear_o` pulse 1 cycle after start; `words_sent_o`=0.
- count_i=3 with `out_ready_i` toggling randomly -> `out_data_o` stable whenever valid&&!ready; 15 words in order, matching the buffer model.
- count_i=0xFFFF -> exactly 8192 entries drained (last address 8191); `words_sent_o`=40960.
- `abort_i` asserted during word 2 of entry 1 -> IDLE next cycle, no `done_o`/`sampler_clear_o`, `words_sent_o`=7. A second start during the abort cycle is ignored.
- `reset_i` asserted asynchronously mid-SEND -> all outputs 0 immediately. A start after release restarts the drain at address 0.

Source files
------------

// File: rtl/sampler_buffer_drain_pkg.sv
// sampler_pkg: types and defaults shared by the lease sampler and its buffer
// drain.
//   - drain_state_e : drain FSM states
//   - word_sel_e    : which field of the latched entry is presented on the stream
//   - DEF_BUFFER_DEPTH / DEF_ADDR_W : reuse-interval buffer geometry
package sampler_pkg;

    localparam int DEF_BUFFER_DEPTH = 8192;
    localparam int DEF_ADDR_W       = 13;
    localparam int WORDS_PER_ENTRY  = 5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LATCH,
        SEND,
        DONE
    } drain_state_e;

    typedef enum logic [2:0] {
        W_ADDRESS,
        W_INTERVAL,
        W_TRACE_LO,
        W_TRACE_HI,
        W_TARGET
    } word_sel_e;

endpackage

// File: rtl/sampler_buffer_drain_if.sv
// sampler_stream_if: 32-bit valid/ready word stream toward the host comm path.
//   data  : stream word
//   valid : data holds a valid word
//   ready : consumer accepts the word this cycle
// master = producer (the drain), slave = consumer.
interface sampler_stream_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sampler_buffer_drain.sv
// sampler_buffer_drain: walks the filled entries of the sampler's
// reuse-interval buffer and serializes each one as five 32-bit words
// (address, interval, trace lo, trace hi, target) onto a valid/ready stream.
// A normal completion pulses done_o and sampler_clear_o together.
// Ports:
//   clock_i, reset_i (async, active high)
//   start_i / abort_i / count_i   : drain control, count sampled on start
//   buf_addr_o, buf_*_i           : buffer read port, one-cycle registered read
//   out_s                         : word stream (master side)
//   busy_o, done_o, sampler_clear_o, words_sent_o : status
//
// state | meaning
// IDLE  | waiting for start_i
// WAIT  | read address issued, BRAM read in flight
// LATCH | capture the four buffer fields into holding registers
// SEND  | present the five words of the current entry
// DONE  | one-cycle done / clear pulse
module sampler_buffer_drain
    import sampler_pkg::*;
#(
    parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [31:0]       count_i,
    output logic [ADDR_W-1:0] buf_addr_o,
    input  logic [31:0]       buf_address_i,
    input  logic [31:0]       buf_interval_i,
    input  logic [63:0]       buf_trace_i,
    input  logic [31:0]       buf_target_i,
    sampler_stream_if.master  out_s,
    output logic              busy_o,
    output logic              done_o,
    output logic              sampler_clear_o,
    output logic [31:0]       words_sent_o
);

    // One extra bit so n can hold BUFFER_DEPTH itself.
    localparam int CNT_W = ADDR_W + 1;

    drain_state_e      state_q, state_d;
    word_sel_e         word_q, word_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] entry_q, entry_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       hold_address_q, hold_address_d;
    logic [31:0]       hold_interval_q, hold_interval_d;
    logic [63:0]       hold_trace_q, hold_trace_d;
    logic [31:0]       hold_target_q, hold_target_d;
    logic [31:0]       words_sent_q, words_sent_d;

    logic [CNT_W-1:0]  entry_inc;
    logic              handshake;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            word_q          <= W_ADDRESS;
            n_q             <= '0;
            entry_q         <= '0;
            addr_q          <= '0;
            hold_address_q  <= '0;
            hold_interval_q <= '0;
            hold_trace_q    <= '0;
            hold_target_q   <= '0;
            words_sent_q    <= '0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            n_q             <= n_d;
            entry_q         <= entry_d;
            addr_q          <= addr_d;
            hold_address_q  <= hold_address_d;
            hold_interval_q <= hold_interval_d;
            hold_trace_q    <= hold_trace_d;
            hold_target_q   <= hold_target_d;
            words_sent_q    <= words_sent_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        n_d             = n_q;
        entry_d         = entry_q;
        addr_d          = addr_q;
        hold_address_d  = hold_address_q;
        hold_interval_d = hold_interval_q;
        hold_trace_d    = hold_trace_q;
        hold_target_d   = hold_target_q;
        words_sent_d    = words_sent_q;
        entry_inc       = {1'b0, entry_q} + CNT_W'(1);
        handshake       = (state_q == SEND) && out_s.ready;

        // Abort overrides everything, including a same-cycle start or handshake.
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_d          = (count_i > 32'(BUFFER_DEPTH)) ? CNT_W'(BUFFER_DEPTH)
                                                                     : count_i[CNT_W-1:0];
                        words_sent_d = '0;
                        entry_d      = '0;
                        if (n_d == '0) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = '0;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: state_d = LATCH;
                LATCH: begin
                    hold_address_d  = buf_address_i;
                    hold_interval_d = buf_interval_i;
                    hold_trace_d    = buf_trace_i;
                    hold_target_d   = buf_target_i;
                    word_d          = W_ADDRESS;
                    state_d         = SEND;
                end
                SEND: begin
                    if (handshake) begin
                        if (words_sent_q != '1) begin
                            words_sent_d = words_sent_q + 32'd1;
                        end
                        if (word_q == W_TARGET) begin
                            if (entry_inc < n_q) begin
                                entry_d = entry_inc[ADDR_W-1:0];
                                addr_d  = entry_inc[ADDR_W-1:0];
                                state_d = WAIT;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            word_d = word_sel_e'(word_q + 3'd1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o          = (state_q != IDLE);
        out_s.valid     = (state_q == SEND);
        done_o          = (state_q == DONE);
        sampler_clear_o = (state_q == DONE);
        buf_addr_o      = addr_q;
        words_sent_o    = words_sent_q;
        case (word_q)
            W_ADDRESS:  out_s.data = hold_address_q;
            W_INTERVAL: out_s.data = hold_interval_q;
            W_TRACE_LO: out_s.data = hold_trace_q[31:0];
            W_TRACE_HI: out_s.data = hold_trace_q[63:32];
            W_TARGET:   out_s.data = hold_target_q;
            default:    out_s.data = '0;
        endcase
    end

endmodule

// File: tb/tb_sampler_buffer_drain.sv
module tb_sampler_buffer_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] count_i = '0;
    logic [12:0] buf_addr;
    logic [31:0] b_address = '0;
    logic [31:0] b_interval = '0;
    logic [63:0] b_trace = '0;
    logic [31:0] b_target = '0;
    logic        busy_o, done_o, clear_o;
    logic [31:0] words_sent_o;

    sampler_stream_if s_if ();

    sampler_buffer_drain #(.BUFFER_DEPTH(8192), .ADDR_W(13)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .count_i        (count_i),
        .buf_addr_o     (buf_addr),
        .buf_address_i  (b_address),
        .buf_interval_i (b_interval),
        .buf_trace_i    (b_trace),
        .buf_target_i   (b_target),
        .out_s          (s_if),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sampler_clear_o(clear_o),
        .words_sent_o   (words_sent_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] sb[$];
    int done_cnt = 0;
    int clear_cnt = 0;
    int hs_cnt = 0;
    int max_addr = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data = '0;

    // Buffer contents model; entry 0 is {0x01000100, 5, 0x2A, 0xAB}.
    function automatic logic [31:0] m_address(int a);
        return 32'h0100_0100 + 32'(a);
    endfunction
    function automatic logic [31:0] m_interval(int a);
        return (a % 2 == 1) ? (32'hFFFF_FFF0 - 32'(a)) : (32'd5 + 32'(a) * 32'd7);
    endfunction
    function automatic logic [63:0] m_trace(int a);
        return {32'(a), 32'h2A + 32'(a)};
    endfunction
    function automatic logic [31:0] m_target(int a);
        return 32'hAB + 32'(a);
    endfunction

    always @(posedge clk) begin
        b_address  <= m_address(int'(buf_addr));
        b_interval <= m_interval(int'(buf_addr));
        b_trace    <= m_trace(int'(buf_addr));
        b_target   <= m_target(int'(buf_addr));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entries(input int n);
        logic [63:0] t;
        for (int e = 0; e < n; e++) begin
            t = m_trace(e);
            sb.push_back(m_address(e));
            sb.push_back(m_interval(e));
            sb.push_back(t[31:0]);
            sb.push_back(t[63:32]);
            sb.push_back(m_target(e));
        end
    endtask

    // Stream monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (s_if.valid && prev_valid && !prev_ready)
                check("hold_stable", s_if.data, prev_data);
            if (s_if.valid && s_if.ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL unexpected_word observed=0x%0h expected=none", s_if.data);
                end else begin
                    check("word", s_if.data, sb.pop_front());
                end
            end
            if (busy_o && int'(buf_addr) > max_addr) max_addr = int'(buf_addr);
            if (done_o) done_cnt++;
            if (clear_o) clear_cnt++;
            if (done_o || clear_o) check("done_eq_clear", clear_o, done_o);
            prev_valid = s_if.valid;
            prev_ready = s_if.ready;
            prev_data  = s_if.data;
        end
    end

    task automatic do_start(input logic [31:0] cnt);
        start_i = 1'b1;
        count_i = cnt;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag, input bit rand_ready);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_o) seen = 1'b1;
            else if (rand_ready) s_if.ready = 1'($urandom_range(0, 1));
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        int d0, h0;
        bit seen;
        s_if.ready = 1'b0;

        // Reset state
        #12;
        check("rst_busy", busy_o, 0);
        check("rst_valid", s_if.valid, 0);
        check("rst_done", done_o, 0);
        check("rst_clear", clear_o, 0);
        check("rst_addr", buf_addr, 0);
        check("rst_words", words_sent_o, 0);
        check("rst_data", s_if.data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two entries, ready always high, latency check
        s_if.ready = 1'b1;
        d0 = done_cnt;
        push_entries(2);
        do_start(32'd2);
        check("t1_busy", busy_o, 1);
        check("t1_addr0", buf_addr, 0);
        check("t1_valid_k", s_if.valid, 0);
        @(posedge clk); #1;
        check("t1_valid_k1", s_if.valid, 0);
        @(posedge clk); #1;
        check("t1_valid_k2", s_if.valid, 1);
        check("t1_first_word", s_if.data, 32'h0100_0100);
        wait_done(100, "t1_done_seen", 1'b0);
        check("t1_clear_hi", clear_o, 1);
        @(posedge clk); #1;
        check("t1_done_lo", done_o, 0);
        check("t1_busy_lo", busy_o, 0);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_words", words_sent_o, 10);
        check("t1_sb_empty", sb.size(), 0);

        // Zero entries
        d0 = done_cnt;
        h0 = hs_cnt;
        do_start(32'd0);
        check("t2_done", done_o, 1);
        check("t2_clear", clear_o, 1);
        check("t2_valid", s_if.valid, 0);
        @(posedge clk); #1;
        check("t2_done_lo", done_o, 0);
        check("t2_busy_lo", busy_o, 0);
        check("t2_words", words_sent_o, 0);
        check("t2_hs", hs_cnt - h0, 0);
        check("t2_done_cnt", done_cnt - d0, 1);

        // Three entries with random backpressure
        h0 = hs_cnt;
        push_entries(3);
        do_start(32'd3);
        wait_done(600, "t3_done_seen", 1'b1);
        s_if.ready = 1'b1;
        @(posedge clk); #1;
        check("t3_words", words_sent_o, 15);
        check("t3_hs", hs_cnt - h0, 15);
        check("t3_sb_empty", sb.size(), 0);

        // Count above depth is clamped to 8192 entries
        h0 = hs_cnt;
        max_addr = 0;
        push_entries(8192);
        do_start(32'h0000_FFFF);
        wait_done(8192 * 7 + 100, "t4_done_seen", 1'b0);
        @(posedge clk); #1;
        check("t4_words", words_sent_o, 40960);
        check("t4_hs", hs_cnt - h0, 40960);
        check("t4_max_addr", max_addr, 8191);
        check("t4_sb_empty", sb.size(), 0);

        // Abort during word 2 of entry 1, with a simultaneous start
        d0 = done_cnt;
        push_entries(3);
        do_start(32'd3);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (words_sent_o == 32'd7) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t5_reached_7", 64'(seen), 1);
        check("t5_valid_before", s_if.valid, 1);
        s_if.ready = 1'b0;
        abort_i = 1'b1;
        start_i = 1'b1;
        count_i = 32'd2;
        @(posedge clk); #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        check("t5_busy", busy_o, 0);
        check("t5_valid", s_if.valid, 0);
        check("t5_words", words_sent_o, 7);
        check("t5_done", done_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_still_idle", busy_o, 0);
        check("t5_no_pulse", done_cnt - d0, 0);
        sb.delete();

        // Asynchronous reset mid-SEND, then restart
        s_if.ready = 1'b1;
        d0 = done_cnt;
        push_entries(2);
        do_start(32'd2);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (words_sent_o >= 32'd2) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("t6_reached_send", 64'(seen), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", s_if.valid, 0);
        check("t6_busy", busy_o, 0);
        check("t6_addr", buf_addr, 0);
        check("t6_words", words_sent_o, 0);
        check("t6_data", s_if.data, 0);
        check("t6_done", done_o, 0);
        check("t6_clear", clear_o, 0);
        sb.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_pulse", done_cnt - d0, 0);
        push_entries(2);
        do_start(32'd2);
        check("t6_restart_addr", buf_addr, 0);
        check("t6_restart_busy", busy_o, 1);
        wait_done(100, "t6_done_seen", 1'b0);
        @(posedge clk); #1;
        check("t6_restart_words", words_sent_o, 10);
        check("t6_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
